udp_cmd_rx: RTL and testbench

Receive-side counterpart of the UDP image-streaming path. Consumes the UDP receive word stream (rec_en/rec_data/rec_pkt_done/rec_byte_num) from the UDP stack in the gmii_rx_clk domain, validates host command packets, and drives registered stream-control outputs for the camera/DDR/image_data path. Each accepted command produces an acknowledge word, held through a valid/ready handshake, for the transmit side. Sits between u_udp receive outputs and the streaming control logic.

---
 rtl/udp_cmd_rx_pkg.sv | 71 +++++++
 rtl/udp_cmd_rx_if.sv | 34 +++
 rtl/udp_cmd_rx.sv | 205 ++++++++++++++++++++
 tb/tb_udp_cmd_rx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_cmd_rx_pkg.sv
// Shared definitions for the UDP command receiver.
// Contents: payload widths, command magic and length, opcode and status codes,
// ack tag, parser FSM state encoding, payload word layouts and small helpers.
package udp_cmd_rx_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTES_W   = 16;
    localparam int unsigned OP_W      = 8;
    localparam int unsigned SEQ_W     = 8;
    localparam int unsigned ARG_W     = 16;
    localparam int unsigned STAT_W    = 8;
    localparam int unsigned TAG_W     = 8;
    localparam int unsigned MODE_W    = 2;
    localparam int unsigned SKIP_W    = 4;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned CNT_MAX   = 3;
    localparam int unsigned MIN_WORDS = 2;

    localparam logic [WORD_W-1:0]  CMD_MAGIC = 32'h5A5A_C0DE;
    localparam logic [BYTES_W-1:0] CMD_BYTES = 16'd12;

    localparam logic [OP_W-1:0] OP_START    = 8'h01;
    localparam logic [OP_W-1:0] OP_STOP     = 8'h02;
    localparam logic [OP_W-1:0] OP_SET_MODE = 8'h03;
    localparam logic [OP_W-1:0] OP_SET_SKIP = 8'h04;
    localparam logic [OP_W-1:0] OP_PING     = 8'h05;

    localparam logic [STAT_W-1:0] ST_OK  = 8'h00;
    localparam logic [STAT_W-1:0] ST_CHK = 8'h01;
    localparam logic [STAT_W-1:0] ST_OP  = 8'h02;
    localparam logic [STAT_W-1:0] ST_LEN = 8'h03;
    localparam logic [STAT_W-1:0] ST_DUP = 8'h04;

    localparam logic [TAG_W-1:0] ACK_TAG = 8'hAC;

    // Camera mode value that is never accepted.
    localparam logic [MODE_W-1:0] MODE_INVALID = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W1        = 3'd1,
        S_W2        = 3'd2,
        S_DONE_WAIT = 3'd3,
        S_EVAL      = 3'd4
    } state_e;

    // Payload word 1 layout.
    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [SEQ_W-1:0] seq;
        logic [ARG_W-1:0] arg;
    } cmd_word_t;

    // Acknowledge word layout.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [OP_W-1:0]   opcode;
        logic [SEQ_W-1:0]  seq;
        logic [STAT_W-1:0] status;
    } ack_word_t;

    function automatic logic [WORD_W-1:0] cmd_checksum(input logic [WORD_W-1:0] w0,
                                                       input logic [WORD_W-1:0] w1);
        return w0 ^ w1;
    endfunction

    function automatic logic op_known(input logic [OP_W-1:0] op);
        return op inside {OP_START, OP_STOP, OP_SET_MODE, OP_SET_SKIP, OP_PING};
    endfunction

endpackage

// File: rtl/udp_cmd_rx_if.sv
// Bus bundle of the UDP command receiver.
// Carries the UDP receive word stream, the registered stream-control outputs
// and the acknowledge valid/ready handshake.
// slave  : the command receiver (consumes rec_*, ack_ready; drives controls/ack)
// master : the surrounding environment (UDP stack, streaming logic, ack consumer)
interface udp_cmd_rx_if;
    import udp_cmd_rx_pkg::*;

    logic                 rec_en;
    logic [WORD_W-1:0]    rec_data;
    logic                 rec_pkt_done;
    logic [BYTES_W-1:0]   rec_byte_num;

    logic                 stream_en;
    logic [MODE_W-1:0]    cam_mode;
    logic [SKIP_W-1:0]    frame_skip;
    logic                 cmd_strb;

    logic                 ack_valid;
    logic                 ack_ready;
    logic [WORD_W-1:0]    ack_data;
    logic                 ack_ovf;

    modport master (
        output rec_en, rec_data, rec_pkt_done, rec_byte_num, ack_ready,
        input  stream_en, cam_mode, frame_skip, cmd_strb, ack_valid, ack_data, ack_ovf
    );

    modport slave (
        input  rec_en, rec_data, rec_pkt_done, rec_byte_num, ack_ready,
        output stream_en, cam_mode, frame_skip, cmd_strb, ack_valid, ack_data, ack_ovf
    );

endinterface

// File: rtl/udp_cmd_rx.sv
// UDP host command receiver.
// Parses 3-word command packets from the UDP receive stream, validates magic,
// length, checksum, opcode and sequence number, applies accepted commands to
// registered stream controls and posts an acknowledge word per command.
// Ports:
//   sys_clk   : gmii_rx_clk, the only clock
//   sys_rst_n : asynchronous reset, active low
//   bus       : udp_cmd_rx_if.slave (receive stream in, controls + ack out)
module udp_cmd_rx
    import udp_cmd_rx_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    udp_cmd_rx_if.slave bus
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0]    w0_q, w0_d;
    cmd_word_t            w1_q, w1_d;
    logic [WORD_W-1:0]    w2_q, w2_d;
    logic                 ovl_q, ovl_d;
    logic [BYTES_W-1:0]   byte_num_q, byte_num_d;
    logic [SEQ_W-1:0]     last_seq_q, last_seq_d;
    logic                 last_seq_vld_q, last_seq_vld_d;

    logic                 stream_en_q, stream_en_d;
    logic [MODE_W-1:0]    cam_mode_q, cam_mode_d;
    logic [SKIP_W-1:0]    frame_skip_q, frame_skip_d;
    logic                 cmd_strb_q, cmd_strb_d;
    logic                 ack_valid_q, ack_valid_d;
    ack_word_t            ack_data_q, ack_data_d;
    logic                 ack_ovf_q, ack_ovf_d;

    logic                 ack_load_c;
    logic                 apply_c;
    logic [STAT_W-1:0]    status_c;

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: end-of-packet wins over word advance (word is still captured).
    always_comb begin
        state_d = state_q;
        if (state_q == S_EVAL) begin
            state_d = S_IDLE;
        end else if (bus.rec_pkt_done) begin
            state_d = S_EVAL;
        end else if (bus.rec_en) begin
            case (state_q)
                S_IDLE:  state_d = S_W1;
                S_W1:    state_d = S_W2;
                S_W2:    state_d = S_DONE_WAIT;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM outputs: packet evaluation, active only in EVAL.
    always_comb begin
        ack_load_c = 1'b0;
        apply_c    = 1'b0;
        status_c   = ST_OK;
        if (state_q == S_EVAL) begin
            if (w0_q != CMD_MAGIC || cnt_q < CNT_W'(MIN_WORDS)) begin
                ack_load_c = 1'b0;
            end else begin
                ack_load_c = 1'b1;
                if (byte_num_q != CMD_BYTES || ovl_q || cnt_q != CNT_W'(CNT_MAX)) begin
                    status_c = ST_LEN;
                end else if (w2_q != cmd_checksum(w0_q, WORD_W'(w1_q))) begin
                    status_c = ST_CHK;
                end else if (!op_known(w1_q.opcode) ||
                             (w1_q.opcode == OP_SET_MODE &&
                              w1_q.arg[MODE_W-1:0] == MODE_INVALID)) begin
                    status_c = ST_OP;
                end else if (last_seq_vld_q && w1_q.seq == last_seq_q) begin
                    status_c = ST_DUP;
                end else begin
                    apply_c = 1'b1;
                end
            end
        end
    end

    // Word capture, saturating word count and overlength tracking.
    always_comb begin
        cnt_d      = cnt_q;
        w0_d       = w0_q;
        w1_d       = w1_q;
        w2_d       = w2_q;
        ovl_d      = ovl_q;
        byte_num_d = byte_num_q;
        if (state_q == S_EVAL) begin
            cnt_d = '0;
            ovl_d = 1'b0;
        end else begin
            if (bus.rec_en) begin
                case (state_q)
                    S_IDLE:      w0_d  = bus.rec_data;
                    S_W1:        w1_d  = cmd_word_t'(bus.rec_data);
                    S_W2:        w2_d  = bus.rec_data;
                    S_DONE_WAIT: ovl_d = 1'b1;
                    default:     ;
                endcase
                if (cnt_q != CNT_W'(CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (bus.rec_pkt_done) begin
                byte_num_d = bus.rec_byte_num;
            end
        end
    end

    // Command application and acknowledge register with overwrite detection.
    always_comb begin
        stream_en_d    = stream_en_q;
        cam_mode_d     = cam_mode_q;
        frame_skip_d   = frame_skip_q;
        last_seq_d     = last_seq_q;
        last_seq_vld_d = last_seq_vld_q;
        cmd_strb_d     = 1'b0;
        ack_valid_d    = ack_valid_q;
        ack_data_d     = ack_data_q;
        ack_ovf_d      = 1'b0;

        if (apply_c) begin
            cmd_strb_d     = 1'b1;
            last_seq_d     = w1_q.seq;
            last_seq_vld_d = 1'b1;
            case (w1_q.opcode)
                OP_START:    stream_en_d  = 1'b1;
                OP_STOP:     stream_en_d  = 1'b0;
                OP_SET_MODE: cam_mode_d   = w1_q.arg[MODE_W-1:0];
                OP_SET_SKIP: frame_skip_d = w1_q.arg[SKIP_W-1:0];
                default:     ;
            endcase
        end

        // A load in the consume cycle replaces the ack without flagging overwrite.
        if (ack_load_c) begin
            ack_valid_d       = 1'b1;
            ack_data_d.tag    = ACK_TAG;
            ack_data_d.opcode = w1_q.opcode;
            ack_data_d.seq    = w1_q.seq;
            ack_data_d.status = status_c;
            ack_ovf_d         = ack_valid_q & ~bus.ack_ready;
        end else if (ack_valid_q && bus.ack_ready) begin
            ack_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q          <= '0;
            w0_q           <= '0;
            w1_q           <= '0;
            w2_q           <= '0;
            ovl_q          <= 1'b0;
            byte_num_q     <= '0;
            last_seq_q     <= '0;
            last_seq_vld_q <= 1'b0;
            stream_en_q    <= 1'b0;
            cam_mode_q     <= '0;
            frame_skip_q   <= '0;
            cmd_strb_q     <= 1'b0;
            ack_valid_q    <= 1'b0;
            ack_data_q     <= '0;
            ack_ovf_q      <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            w0_q           <= w0_d;
            w1_q           <= w1_d;
            w2_q           <= w2_d;
            ovl_q          <= ovl_d;
            byte_num_q     <= byte_num_d;
            last_seq_q     <= last_seq_d;
            last_seq_vld_q <= last_seq_vld_d;
            stream_en_q    <= stream_en_d;
            cam_mode_q     <= cam_mode_d;
            frame_skip_q   <= frame_skip_d;
            cmd_strb_q     <= cmd_strb_d;
            ack_valid_q    <= ack_valid_d;
            ack_data_q     <= ack_data_d;
            ack_ovf_q      <= ack_ovf_d;
        end
    end

    assign bus.stream_en  = stream_en_q;
    assign bus.cam_mode   = cam_mode_q;
    assign bus.frame_skip = frame_skip_q;
    assign bus.cmd_strb   = cmd_strb_q;
    assign bus.ack_valid  = ack_valid_q;
    assign bus.ack_data   = ack_data_q;
    assign bus.ack_ovf    = ack_ovf_q;

endmodule

// File: tb/tb_udp_cmd_rx.sv
// Testbench for udp_cmd_rx: directed command packets, a packet-level reference
// model compared every cycle, and literal expectations after each scenario.
module tb_udp_cmd_rx;

    localparam logic [31:0] MAGIC = 32'h5A5A_C0DE;

    logic clk;
    logic rst_n;

    udp_cmd_rx_if bus_if();

    udp_cmd_rx dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int strb_cnt = 0;
    int ovf_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    bit          m_stream;
    logic [1:0]  m_mode;
    logic [3:0]  m_skip;
    bit          m_strb;
    bit          m_ovf;
    bit          m_valid;
    logic [31:0] m_ack;
    logic [7:0]  m_seq;
    bit          m_seq_vld;
    logic [31:0] cur_w [0:3];
    int          cur_n;
    logic [31:0] pw [0:3];
    int          pn;
    logic [15:0] pb;
    bit          pend;
    bit          r_ack;
    bit          r_ok;
    logic [7:0]  r_st;
    logic [7:0]  r_op;
    logic [7:0]  r_seq;
    logic [15:0] r_arg;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_stream = 0; m_mode = 0; m_skip = 0; m_strb = 0; m_ovf = 0;
            m_valid = 0; m_ack = 0; m_seq = 0; m_seq_vld = 0;
            cur_n = 0; pn = 0; pb = 0; pend = 0;
            for (int i = 0; i < 4; i++) begin
                cur_w[i] = 0;
                pw[i] = 0;
            end
        end else begin
            m_strb = 0;
            m_ovf  = 0;
            if (pend) begin
                pend  = 0;
                r_op  = pw[1][31:24];
                r_seq = pw[1][23:16];
                r_arg = pw[1][15:0];
                r_ok  = 0;
                r_st  = 8'h00;
                r_ack = !(pn < 2 || pw[0] != MAGIC);
                if (r_ack) begin
                    if (pb != 16'd12 || pn != 3)                         r_st = 8'h03;
                    else if (pw[2] != (pw[0] ^ pw[1]))                   r_st = 8'h01;
                    else if (r_op < 8'h01 || r_op > 8'h05 ||
                             (r_op == 8'h03 && r_arg[1:0] == 2'd3))      r_st = 8'h02;
                    else if (m_seq_vld && r_seq == m_seq)                r_st = 8'h04;
                    else                                                 r_ok = 1;
                end
                if (r_ack) begin
                    m_ovf   = m_valid && !bus_if.ack_ready;
                    m_valid = 1;
                    m_ack   = {8'hAC, r_op, r_seq, r_st};
                end else if (m_valid && bus_if.ack_ready) begin
                    m_valid = 0;
                end
                if (r_ok) begin
                    m_strb    = 1;
                    m_seq     = r_seq;
                    m_seq_vld = 1;
                    if (r_op == 8'h01) m_stream = 1;
                    if (r_op == 8'h02) m_stream = 0;
                    if (r_op == 8'h03) m_mode   = r_arg[1:0];
                    if (r_op == 8'h04) m_skip   = r_arg[3:0];
                end
            end else if (m_valid && bus_if.ack_ready) begin
                m_valid = 0;
            end
            if (bus_if.rec_en) begin
                if (cur_n < 4) cur_w[cur_n] = bus_if.rec_data;
                cur_n++;
            end
            if (bus_if.rec_pkt_done) begin
                pw   = cur_w;
                pn   = cur_n;
                pb   = bus_if.rec_byte_num;
                pend = 1;
                cur_n = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("stream_en",  32'(bus_if.stream_en),  32'(m_stream));
        check("cam_mode",   32'(bus_if.cam_mode),   32'(m_mode));
        check("frame_skip", 32'(bus_if.frame_skip), 32'(m_skip));
        check("cmd_strb",   32'(bus_if.cmd_strb),   32'(m_strb));
        check("ack_valid",  32'(bus_if.ack_valid),  32'(m_valid));
        check("ack_ovf",    32'(bus_if.ack_ovf),    32'(m_ovf));
        if (m_valid) check("ack_data", bus_if.ack_data, m_ack);
        if (bus_if.cmd_strb === 1'b1) strb_cnt++;
        if (bus_if.ack_ovf === 1'b1)  ovf_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mkw1(input logic [7:0] op, input logic [7:0] seq,
                                         input logic [15:0] arg);
        return {op, seq, arg};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] d, input int n, input logic [15:0] bn,
                        input bit coinc, input bit rdy_load);
        logic [31:0] w [0:3];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int i = 0; i < n; i++) begin
            bus_if.rec_en   = 1'b1;
            bus_if.rec_data = w[i];
            if (coinc && i == n - 1) begin
                bus_if.rec_pkt_done = 1'b1;
                bus_if.rec_byte_num = bn;
            end
            step();
        end
        bus_if.rec_en = 1'b0;
        if (!coinc) begin
            bus_if.rec_pkt_done = 1'b1;
            bus_if.rec_byte_num = bn;
            step();
        end
        bus_if.rec_pkt_done = 1'b0;
        bus_if.ack_ready    = rdy_load;
        step();
        bus_if.ack_ready    = 1'b0;
        repeat (3) step();
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] seq, input logic [15:0] arg);
        logic [31:0] x;
        x = mkw1(op, seq, arg);
        send(MAGIC, x, MAGIC ^ x, 32'h0, 3, 16'd12, 1'b0, 1'b0);
    endtask

    task automatic consume();
        bus_if.ack_ready = 1'b1;
        step();
        bus_if.ack_ready = 1'b0;
        step();
    endtask

    logic [31:0] t;

    initial begin
        rst_n = 1'b0;
        bus_if.rec_en = 0; bus_if.rec_data = 0; bus_if.rec_pkt_done = 0;
        bus_if.rec_byte_num = 0; bus_if.ack_ready = 0;
        repeat (3) step();
        check("rst_stream", 32'(bus_if.stream_en), 32'd0);
        check("rst_ackv",   32'(bus_if.ack_valid), 32'd0);
        check("rst_ackd",   bus_if.ack_data,       32'h0);
        rst_n = 1'b1;
        step();

        // START seq 07
        send_cmd(8'h01, 8'h07, 16'h0000);
        check("start_stream", 32'(bus_if.stream_en), 32'd1);
        check("start_ack",    bus_if.ack_data,       32'hAC01_0700);
        check("start_strb",   32'(strb_cnt),         32'd1);
        repeat (4) step();
        check("start_hold",   32'(bus_if.ack_valid), 32'd1);
        consume();
        check("start_cons",   32'(bus_if.ack_valid), 32'd0);

        // SET_MODE 2 seq 08, then duplicate seq 08 with arg 1
        send_cmd(8'h03, 8'h08, 16'h0002);
        check("mode_val", 32'(bus_if.cam_mode), 32'd2);
        check("mode_ack", bus_if.ack_data,      32'hAC03_0800);
        consume();
        send_cmd(8'h03, 8'h08, 16'h0001);
        check("dup_mode", 32'(bus_if.cam_mode), 32'd2);
        check("dup_ack",  bus_if.ack_data,      32'hAC03_0804);
        check("dup_strb", 32'(strb_cnt),        32'd2);
        consume();

        // Bad checksum
        t = mkw1(8'h04, 8'h09, 16'h0007);
        send(MAGIC, t, (MAGIC ^ t) ^ 32'h1, 32'h0, 3, 16'd12, 1'b0, 1'b0);
        check("chk_ack",  bus_if.ack_data,        32'hAC04_0901);
        check("chk_skip", 32'(bus_if.frame_skip), 32'd0);
        consume();

        // Unknown opcode, SET_MODE arg 3
        send_cmd(8'h09, 8'h0A, 16'h0000);
        check("op_ack", bus_if.ack_data, 32'hAC09_0A02);
        consume();
        send_cmd(8'h03, 8'h0B, 16'h0003);
        check("mode3_ack",  bus_if.ack_data,      32'hAC03_0B02);
        check("mode3_mode", 32'(bus_if.cam_mode), 32'd2);
        consume();

        // Short packet: 2 words
        t = mkw1(8'h02, 8'h0C, 16'h0000);
        send(MAGIC, t, 32'h0, 32'h0, 2, 16'd8, 1'b0, 1'b0);
        check("short_ack",    bus_if.ack_data,       32'hAC02_0C03);
        check("short_stream", 32'(bus_if.stream_en), 32'd1);
        consume();

        // Overlength: 4 words, byte_num 16
        t = mkw1(8'h05, 8'h0D, 16'h0000);
        send(MAGIC, t, MAGIC ^ t, 32'hDEAD_BEEF, 4, 16'd16, 1'b0, 1'b0);
        check("long_ack", bus_if.ack_data, 32'hAC05_0D03);
        consume();

        // Bad magic: silent drop
        t = mkw1(8'h02, 8'h0F, 16'h0000);
        send(32'h1234_5678, t, 32'h1234_5678 ^ t, 32'h0, 3, 16'd12, 1'b0, 1'b0);
        check("magic_ackv", 32'(bus_if.ack_valid), 32'd0);
        check("magic_strb", 32'(strb_cnt),         32'd2);

        // rec_pkt_done coincident with the last word: STOP seq 0E
        t = mkw1(8'h02, 8'h0E, 16'h0000);
        send(MAGIC, t, MAGIC ^ t, 32'h0, 3, 16'd12, 1'b1, 1'b0);
        check("coinc_stream", 32'(bus_if.stream_en), 32'd0);
        check("coinc_ack",    bus_if.ack_data,       32'hAC02_0E00);
        consume();

        // Overwrite of an unconsumed ack
        send_cmd(8'h05, 8'h10, 16'h0000);
        send_cmd(8'h04, 8'h11, 16'h0003);
        check("ovf_cnt",  32'(ovf_cnt),           32'd1);
        check("ovf_ack",  bus_if.ack_data,        32'hAC04_1100);
        check("ovf_skip", 32'(bus_if.frame_skip), 32'd3);
        consume();

        // New ack in the consume cycle
        send_cmd(8'h05, 8'h12, 16'h0000);
        t = mkw1(8'h05, 8'h13, 16'h0000);
        send(MAGIC, t, MAGIC ^ t, 32'h0, 3, 16'd12, 1'b0, 1'b1);
        check("same_ovf",  32'(ovf_cnt),           32'd1);
        check("same_ackv", 32'(bus_if.ack_valid), 32'd1);
        check("same_ack",  bus_if.ack_data,        32'hAC05_1300);
        check("same_strb", 32'(strb_cnt),          32'd7);

        // Reset after w1 of SET_SKIP 5, then full SET_SKIP 5 seq 00
        t = mkw1(8'h04, 8'h00, 16'h0005);
        bus_if.rec_en = 1'b1; bus_if.rec_data = MAGIC; step();
        bus_if.rec_data = t; step();
        bus_if.rec_en = 1'b0;
        rst_n = 1'b0;
        step();
        check("mid_rst_skip", 32'(bus_if.frame_skip), 32'd0);
        check("mid_rst_mode", 32'(bus_if.cam_mode),   32'd0);
        check("mid_rst_ackv", 32'(bus_if.ack_valid),  32'd0);
        step();
        rst_n = 1'b1;
        step();
        send_cmd(8'h04, 8'h00, 16'h0005);
        check("post_rst_skip", 32'(bus_if.frame_skip), 32'd5);
        check("post_rst_ack",  bus_if.ack_data,        32'hAC04_0000);
        check("post_rst_strb", 32'(strb_cnt),          32'd8);
        consume();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
